// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes, FSM states
// and the register-index width helper.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to register index decode with range and read-only lookup.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REGS-1:0]   ro_mask,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  is_ro
);

  localparam int OFS_W = $clog2(DATA_WIDTH / 8);

  // Byte-offset bits inside a register carry no meaning here.
  logic unused_ofs;
  assign unused_ofs = ^addr[OFS_W-1:0];

  assign idx   = addr[OFS_W +: IDX_W];
  assign is_ro = ro_mask[idx];

  generate
    if (ADDR_WIDTH > OFS_W + IDX_W) begin : g_hi
      assign in_range = ~|addr[ADDR_WIDTH-1:OFS_W+IDX_W];
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, read-only status
// registers and independent AW/W capture.
//
// state  | meaning
// W_IDLE | collecting AW and W; commits once both are present
// W_RESP | write response pending until bready
// R_IDLE | ready for a read address
// R_DATA | read data pending until rready
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                 DATA_WIDTH = 32,
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_REGS);

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_fire, w_fire, ar_fire, commit;

  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic [IDX_W-1:0]      widx, ridx;
  logic                  w_in_range, w_is_ro, r_in_range, r_is_ro;

  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw_arr [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_e                 bresp_q, rresp_q;

  // A held beat takes priority over the bus, which is not ready for it anyway.
  assign waddr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wdata = w_held  ? w_data_q  : s_axi_wdata;
  assign wstrb = w_held  ? w_strb_q  : s_axi_wstrb;

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_aw_decode (
    .addr(waddr), .ro_mask(RO_MASK), .idx(widx), .in_range(w_in_range), .is_ro(w_is_ro)
  );

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_ar_decode (
    .addr(s_axi_araddr), .ro_mask(RO_MASK), .idx(ridx), .in_range(r_in_range), .is_ro(r_is_ro)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Readies are gated by aresetn so they read 0 while reset is asserted.
  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    commit        = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = aresetn & ~aw_held;
        s_axi_wready  = aresetn & ~w_held;
        aw_fire       = s_axi_awvalid & s_axi_awready;
        w_fire        = s_axi_wvalid & s_axi_wready;
        if ((aw_held | aw_fire) & (w_held | w_fire)) begin
          commit  = 1'b1;
          wr_next = W_RESP;
        end
      end
      W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    ar_fire       = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi_arready = aresetn;
        ar_fire       = s_axi_arvalid & aresetn;
        if (ar_fire) rd_next = R_DATA;
      end
      R_DATA:  if (s_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        if (w_in_range && !w_is_ro) begin
          bresp_q          <= OKAY;
          wr_pulse_q[widx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end else begin
          bresp_q <= SLVERR;
        end
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end
    end
  end

  // Nonblocking update means a same-edge read sees the pre-write contents.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_fire) begin
      if (!r_in_range) begin
        rdata_q <= '0;
        rresp_q <= SLVERR;
      end else begin
        rdata_q <= r_is_ro ? hw_arr[ridx] : regs[ridx];
        rresp_q <= OKAY;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
      assign hw_arr[i] = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign s_axi_bvalid = (wr_state == W_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (rd_state == R_DATA);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile: directed scenarios plus random
// traffic compared against an address-arithmetic register model.
module tb_axi4_lite_regfile;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 8;
  localparam logic [NR-1:0] RO = 8'h80;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [AW-1:0]  s_axi_awaddr = '0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [DW-1:0]  s_axi_wdata = '0;
  logic [3:0]     s_axi_wstrb = '0;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] hw_status;
  logic [NR-1:0]  reg_wr_pulse;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [NR];
  logic [31:0] hw    [NR];

  always #5 aclk = ~aclk;

  always_comb begin
    hw_status = '0;
    for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = hw[i];
  end

  axi4_lite_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .reg_q(reg_q),
    .hw_status(hw_status), .reg_wr_pulse(reg_wr_pulse)
  );

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse);
    int idx;
    pulse = '0;
    resp  = 2'b10;
    if (addr < NR * 4) begin
      idx = int'(addr / 4);
      if (!RO[idx]) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        pulse[idx] = 1'b1;
        resp = 2'b00;
      end
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx;
    data = '0;
    resp = 2'b10;
    if (addr < NR * 4) begin
      idx  = int'(addr / 4);
      data = RO[idx] ? hw[idx] : model[idx];
      resp = 2'b00;
    end
  endtask

  function automatic logic [NR*DW-1:0] model_q();
    logic [NR*DW-1:0] q;
    q = '0;
    for (int i = 0; i < NR; i++) q[i*DW +: DW] = RO[i] ? 32'h0 : model[i];
    return q;
  endfunction

  // ---------------- bus drivers (sample at posedge+1) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall,
                           output logic [1:0] resp, output logic [7:0] p1, output logic [7:0] p2,
                           output bit lat_ok, output bit viol, output bit to);
    bit aw_done, w_done, aw_f, w_f;
    int n;
    aw_done = 0; w_done = 0; n = 0; viol = 0; to = 0; lat_ok = 0;
    resp = '0; p1 = '0; p2 = '0;
    while (!(aw_done && w_done)) begin
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_awvalid = !aw_done && (n >= aw_dly);
      s_axi_wvalid  = !w_done && (n >= w_dly);
      if (aw_done && s_axi_awready) viol = 1;
      if (w_done && s_axi_wready) viol = 1;
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      n++;
      if (n > 40) begin to = 1; break; end
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    if (to) return;
    lat_ok = s_axi_bvalid;
    resp   = s_axi_bresp;
    p1     = reg_wr_pulse;
    for (int i = 0; i < b_stall; i++) begin
      if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_wready) viol = 1;
      @(posedge aclk); #1;
      if (reg_wr_pulse !== '0) viol = 1;
    end
    s_axi_bready = 1;
    @(posedge aclk); #1;
    s_axi_bready = 0;
    p2 = reg_wr_pulse;
    if (s_axi_bvalid) viol = 1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_stall,
                          output logic [31:0] data, output logic [1:0] resp, output int ar_wait,
                          output bit lat_ok, output bit viol, output bit to);
    bit fire;
    fire = 0; ar_wait = 0; lat_ok = 0; viol = 0; to = 0; data = '0; resp = '0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1;
    while (!fire && ar_wait < 40) begin
      fire = s_axi_arready;
      @(posedge aclk); #1;
      ar_wait++;
    end
    s_axi_arvalid = 0;
    if (!fire) begin to = 1; return; end
    lat_ok = s_axi_rvalid;
    data   = s_axi_rdata;
    resp   = s_axi_rresp;
    for (int i = 0; i < r_stall; i++) begin
      if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp || s_axi_arready) viol = 1;
      @(posedge aclk); #1;
    end
    s_axi_rready = 1;
    @(posedge aclk); #1;
    s_axi_rready = 0;
    if (s_axi_rvalid) viol = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 0;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshake got=%b exp=00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    checks++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_wr_pulse} !== '0 || reg_q !== '0) begin
      failures++;
      $display("FAIL reset_outputs got resp=%h rdata=%h pulse=%h exp all 0",
               {s_axi_bresp, s_axi_rresp}, s_axi_rdata, reg_wr_pulse);
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    model_clear();
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic [7:0] p1, p2, ep; logic [31:0] d; logic [1:0] er; int aw_w; bit lat, viol, to;
    model_write(32'h04, 32'hDEADBEEF, 4'hF, er, ep);
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (to || !lat || viol) begin
      failures++; $display("FAIL same_proto got to=%0d bvalid_t1=%0d viol=%0d exp 0/1/0", to, lat, viol);
    end
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL same_bresp got=%h exp=0", r); end
    checks++;
    if (p1 !== 8'h02 || p2 !== 8'h00) begin
      failures++; $display("FAIL same_pulse got=%h,%h exp=02,00", p1, p2);
    end
    axi_read(32'h04, 0, d, r, aw_w, lat, viol, to);
    checks++;
    if (to || !lat || viol || d !== 32'hDEADBEEF || r !== 2'b00) begin
      failures++; $display("FAIL same_read got=%h/%h exp=deadbeef/0", d, r);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] r, er; logic [7:0] p1, p2, ep; bit lat, viol, to;
    model_write(32'h08, 32'hA5A5A5A5, 4'hF, er, ep);
    axi_write(32'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (to || !lat || viol) begin
      failures++; $display("FAIL wfirst_proto got to=%0d bvalid_t1=%0d viol=%0d exp 0/1/0", to, lat, viol);
    end
    checks++;
    if (r !== 2'b00 || p1 !== 8'h04) begin
      failures++; $display("FAIL wfirst_resp got=%h pulse=%h exp=0 pulse=04", r, p1);
    end
    checks++;
    if (reg_q[2*DW +: DW] !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL wfirst_reg2 got=%h exp=a5a5a5a5", reg_q[2*DW +: DW]);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, er; logic [7:0] p1, p2, ep; bit lat, viol, to;
    model_write(32'h0C, 32'h11223344, 4'hF, er, ep);
    axi_write(32'h0C, 32'h11223344, 4'hF, 1, 0, 0, r, p1, p2, lat, viol, to);
    model_write(32'h0D, 32'hFFFFFFFF, 4'b0101, er, ep);
    axi_write(32'h0D, 32'hFFFFFFFF, 4'b0101, 0, 2, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (reg_q[3*DW +: DW] !== 32'h11FF33FF || r !== 2'b00) begin
      failures++; $display("FAIL strobe_reg3 got=%h resp=%h exp=11ff33ff resp=0", reg_q[3*DW +: DW], r);
    end
    model_write(32'h0C, 32'h0, 4'h0, er, ep);
    axi_write(32'h0C, 32'h0, 4'h0, 0, 0, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (reg_q[3*DW +: DW] !== 32'h11FF33FF || r !== 2'b00 || p1 !== 8'h08) begin
      failures++; $display("FAIL strobe_zero got=%h resp=%h pulse=%h exp=11ff33ff/0/08",
                           reg_q[3*DW +: DW], r, p1);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [7:0] p1, p2; logic [31:0] d; int aw_w; bit lat, viol, to;
    axi_write(32'h20, 32'h12345678, 4'hF, 0, 0, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (to || r !== 2'b10 || p1 !== 8'h00) begin
      failures++; $display("FAIL err_oor_write got=%h pulse=%h exp=2 pulse=00", r, p1);
    end
    axi_write(32'h1C, 32'h12345678, 4'hF, 0, 0, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (to || r !== 2'b10 || p1 !== 8'h00 || reg_q !== model_q()) begin
      failures++; $display("FAIL err_ro_write got=%h pulse=%h reg7=%h exp=2 pulse=00 reg7=0",
                           r, p1, reg_q[7*DW +: DW]);
    end
    hw[7] = 32'hCAFE0001;
    axi_read(32'h1C, 0, d, r, aw_w, lat, viol, to);
    checks++;
    if (to || d !== 32'hCAFE0001 || r !== 2'b00) begin
      failures++; $display("FAIL err_ro_read got=%h/%h exp=cafe0001/0", d, r);
    end
    axi_read(32'h40, 0, d, r, aw_w, lat, viol, to);
    checks++;
    if (to || d !== 32'h0 || r !== 2'b10) begin
      failures++; $display("FAIL err_oor_read got=%h/%h exp=0/2", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] wr, rr, er, err_r; logic [7:0] p1, p2, ep; logic [31:0] d, ed;
    int ar_w; bit wl, wv, wt, rl, rv, rt;
    model_write(32'h18, 32'h600DF00D, 4'hF, er, ep);
    model_read(32'h04, ed, err_r);
    fork
      axi_write(32'h18, 32'h600DF00D, 4'hF, 0, 0, 10, wr, p1, p2, wl, wv, wt);
      begin
        repeat (3) begin @(posedge aclk); #1; end
        axi_read(32'h04, 10, d, rr, ar_w, rl, rv, rt);
      end
    join
    checks++;
    if (wt || !wl || wv || wr !== er || p1 !== ep || p2 !== 8'h00) begin
      failures++; $display("FAIL bp_write got to=%0d lat=%0d viol=%0d resp=%h pulse=%h exp 0/1/0/%h/%h",
                           wt, wl, wv, wr, p1, er, ep);
    end
    checks++;
    if (rt || !rl || rv || ar_w !== 1 || d !== ed || rr !== err_r) begin
      failures++; $display("FAIL bp_read got to=%0d lat=%0d viol=%0d arwait=%0d data=%h exp 0/1/0/1/%h",
                           rt, rl, rv, ar_w, d, ed);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] wr, rr, er; logic [7:0] p1, p2, ep; logic [31:0] d, old;
    int ar_w; bit wl, wv, wt, rl, rv, rt;
    model_write(32'h14, 32'h55AA55AA, 4'hF, er, ep);
    axi_write(32'h14, 32'h55AA55AA, 4'hF, 0, 0, 0, wr, p1, p2, wl, wv, wt);
    old = model[5];
    model_write(32'h14, 32'h12345678, 4'hF, er, ep);
    fork
      axi_write(32'h14, 32'h12345678, 4'hF, 0, 0, 0, wr, p1, p2, wl, wv, wt);
      axi_read(32'h14, 0, d, rr, ar_w, rl, rv, rt);
    join
    checks++;
    if (rt || d !== old || rr !== 2'b00) begin
      failures++; $display("FAIL simul_read got=%h exp=%h (pre-write value)", d, old);
    end
    checks++;
    if (wt || wr !== er || reg_q !== model_q()) begin
      failures++; $display("FAIL simul_write got resp=%h reg5=%h exp=%h/%h", wr, reg_q[5*DW +: DW], er, model[5]);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r, er; logic [7:0] p1, p2, ep; bit lat, viol, to, seen;
    s_axi_awaddr = 32'h0C; s_axi_awvalid = 1;
    @(posedge aclk); #1;
    s_axi_awvalid = 0;
    checks++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b1) begin
      failures++; $display("FAIL mid_held got aw=%b w=%b exp aw=0 w=1", s_axi_awready, s_axi_wready);
    end
    aresetn = 0;
    #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b0 || reg_q !== '0) begin
      failures++; $display("FAIL mid_reset got=%b exp=0000 with reg_q 0",
                           {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
    end
    model_clear();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    seen = 0;
    repeat (5) begin
      @(posedge aclk); #1;
      if (s_axi_bvalid) seen = 1;
    end
    checks++;
    if (seen || reg_q !== '0) begin
      failures++; $display("FAIL mid_no_resp got bvalid_seen=%0d exp=0", seen);
    end
    model_write(32'h10, 32'hFEEDC0DE, 4'hF, er, ep);
    axi_write(32'h10, 32'hFEEDC0DE, 4'hF, 0, 1, 0, r, p1, p2, lat, viol, to);
    checks++;
    if (to || !lat || viol || r !== er || p1 !== ep || reg_q !== model_q()) begin
      failures++; $display("FAIL mid_next_write got resp=%h pulse=%h reg4=%h exp=%h/%h/feedc0de",
                           r, p1, reg_q[4*DW +: DW], er, ep);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed, got; logic [3:0] s; logic [1:0] er, r; logic [7:0] ep, p1, p2;
    int ar_w; bit lat, viol, to;
    for (int it = 0; it < 60; it++) begin
      a = $urandom_range(0, 32'h47);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          d = $urandom;
          s = 4'($urandom_range(0, 15));
          model_write(a, d, s, er, ep);
          axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    r, p1, p2, lat, viol, to);
          checks++;
          if (to || !lat || viol || r !== er || p1 !== ep || p2 !== 8'h00) begin
            failures++; $display("FAIL rnd_write a=%h got resp=%h pulse=%h exp resp=%h pulse=%h to=%0d viol=%0d",
                                 a, r, p1, er, ep, to, viol);
          end
        end
        1: begin
          model_read(a, ed, er);
          axi_read(a, $urandom_range(0, 2), got, r, ar_w, lat, viol, to);
          checks++;
          if (to || !lat || viol || got !== ed || r !== er) begin
            failures++; $display("FAIL rnd_read a=%h got=%h/%h exp=%h/%h", a, got, r, ed, er);
          end
        end
        default: begin
          hw[$urandom_range(0, NR-1)] = $urandom;
          @(posedge aclk); #1;
        end
      endcase
      checks++;
      if (reg_q !== model_q()) begin
        failures++; $display("FAIL rnd_reg_q it=%0d got=%h exp=%h", it, reg_q, model_q());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) hw[i] = '0;
    model_clear();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_strobe();
    test_errors();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
